// File: rtl/mips_pkg.sv
// Shared MIPS multicycle definitions: opcodes, FSM states,
// ALU op and datapath select encodings, control bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] aluop;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control: opcode-driven FSM producing
// all datapath strobes, mux selects and the aluop field.
module main_control_fsm
    import mips_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           pc_write,
    output logic           pc_write_cond,
    output logic           iord,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     pc_source,
    output logic [1:0]     aluop,
    output logic           illegal_op,
    output logic [3:0]     state
);

    state_t cur, nxt;
    ctrl_t  ctl;

    logic is_r, is_lw, is_sw, is_beq, is_j, is_addi, legal;

    assign is_r    = (opcode == OPW'(OP_RTYPE));
    assign is_lw   = (opcode == OPW'(OP_LW));
    assign is_sw   = (opcode == OPW'(OP_SW));
    assign is_beq  = (opcode == OPW'(OP_BEQ));
    assign is_j    = (opcode == OPW'(OP_J));
    assign is_addi = (opcode == OPW'(OP_ADDI));
    assign legal   = is_r | is_lw | is_sw | is_beq | is_j | is_addi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= S_FETCH;
        else       cur <= nxt;
    end

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:    nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_lw | is_sw) nxt = S_MEM_ADDR;
                else if (is_r)     nxt = S_EXEC;
                else if (is_beq)   nxt = S_BRANCH;
                else if (is_j)     nxt = S_JUMP;
                else if (is_addi)  nxt = S_ADDI_EX;
                else               nxt = S_FETCH;
            end
            S_MEM_ADDR: nxt = is_lw ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   nxt = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   nxt = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC:     nxt = S_R_WB;
            S_ADDI_EX:  nxt = S_ADDI_WB;
            default:    nxt = S_FETCH;
        endcase
    end

    always_comb begin
        ctl = '0;
        case (cur)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.ir_write  = mem_ready;
                ctl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctl.alu_src_b  = SRCB_IMM_SH;
                ctl.illegal_op = ~legal;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.aluop     = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.aluop         = ALUOP_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PCSRC_JUMP;
            end
            S_ADDI_WB: ctl.reg_write = 1'b1;
            default: ctl = '0;
        endcase
        // FETCH is the reset state, so its strobes must be masked here
        if (reset) ctl = '0;
    end

    assign pc_write      = ctl.pc_write;
    assign pc_write_cond = ctl.pc_write_cond;
    assign iord          = ctl.iord;
    assign mem_read      = ctl.mem_read;
    assign mem_write     = ctl.mem_write;
    assign ir_write      = ctl.ir_write;
    assign reg_dst       = ctl.reg_dst;
    assign mem_to_reg    = ctl.mem_to_reg;
    assign reg_write     = ctl.reg_write;
    assign alu_src_a     = ctl.alu_src_a;
    assign alu_src_b     = ctl.alu_src_b;
    assign pc_source     = ctl.pc_source;
    assign aluop         = ctl.aluop;
    assign illegal_op    = ctl.illegal_op;
    assign state         = cur;

endmodule

// File: tb/tb_main_control_fsm.sv
// Randomized bench for main_control_fsm against a per-opcode
// state-path model and a per-state output table.
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write;
    logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source, aluop;
    logic       illegal_op;
    logic [3:0] state;

    int errs = 0;
    int checks = 0;
    int path[$];

    logic [16:0] obs;
    assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write,
                  ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                  alu_src_b, pc_source, aluop, illegal_op};

    main_control_fsm #(.OPW(6)) dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .mem_ready(mem_ready), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_source(pc_source), .aluop(aluop),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input int unsigned got,
                       input int unsigned want);
        checks++;
        if (got != want) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // expected outputs, written field by field from the state table
    function automatic logic [16:0] exp_out(int st, bit mr, bit bad);
        bit pw = 0, pwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0;
        bit rd = 0, m2r = 0, rw = 0, sa = 0, ill = 0;
        bit [1:0] sb = 0, ps = 0, op = 0;
        case (st)
            0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            1:  begin sb = 2'b11; ill = bad; end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mrd = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; io = 1; end
            6:  begin sa = 1; op = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin sa = 1; sb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, io, mrd, mwr, irw, rd, m2r, rw, sa,
                sb, ps, op, ill};
    endfunction

    task automatic set_path(input bit [5:0] op);
        case (op)
            6'b000000: path = '{0, 1, 6, 7};
            6'b100011: path = '{0, 1, 2, 3, 4};
            6'b101011: path = '{0, 1, 2, 5};
            6'b000100: path = '{0, 1, 8};
            6'b000010: path = '{0, 1, 9};
            6'b001000: path = '{0, 1, 10, 11};
            default:   path = '{0, 1};
        endcase
    endtask

    task automatic run_instr(input bit [5:0] op, input int fst,
                             input int mst, input bit rnd);
        int idx = 0;
        int guard = 0;
        int fs = fst;
        int ms = mst;
        int st;
        bit waits, bad;
        set_path(op);
        bad = (path.size() == 2);
        while (idx < path.size()) begin
            @(negedge clk);
            st = path[idx];
            if (st == 0) opcode = op;
            waits = (st == 0) || (st == 3) || (st == 5);
            if (!waits) begin
                mem_ready = 1'($urandom_range(0, 1));
            end else if (rnd) begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end else if (st == 0) begin
                mem_ready = (fs == 0);
                if (fs > 0) fs--;
            end else begin
                mem_ready = (ms == 0);
                if (ms > 0) ms--;
            end
            #1;
            chk($sformatf("state op=%b", op), state, st);
            chk($sformatf("outs op=%b st=%0d", op, st), obs,
                exp_out(st, mem_ready, bad));
            chk("wr_excl", $countones({reg_write, mem_write, pc_write}) <= 1, 1);
            if (!(waits && !mem_ready)) idx++;
            guard++;
            if (guard > 200) begin
                chk("stall_bound", guard, 200);
                idx = path.size();
            end
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rel_mem_read", mem_read, 1);
        chk("rel_ir_write", ir_write, 1);
        chk("rel_pc_write", pc_write, 1);
        chk("rel_state", state, 0);
    endtask

    initial begin
        bit [5:0] legal_ops [6];
        bit [5:0] op;
        legal_ops = '{6'b000000, 6'b100011, 6'b101011,
                      6'b000100, 6'b000010, 6'b001000};

        reset = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_state", state, 0);
            chk("rst_outs", obs, 0);
        end
        release_reset();

        run_instr(6'b000000, 0, 0, 1'b0);
        run_instr(6'b100011, 0, 2, 1'b0);
        run_instr(6'b000100, 0, 0, 1'b0);
        run_instr(6'b000010, 0, 0, 1'b0);
        run_instr(6'b111111, 0, 0, 1'b0);
        run_instr(6'b001000, 2, 0, 1'b0);
        run_instr(6'b101011, 1, 3, 1'b0);

        // sw stalled in MEM_WR, then async reset between edges
        @(negedge clk); opcode = 6'b101011; mem_ready = 1'b1;
        #1 chk("sw_f", state, 0);
        @(negedge clk); #1 chk("sw_d", state, 1);
        @(negedge clk); #1 chk("sw_a", state, 2);
        @(negedge clk); mem_ready = 1'b0;
        #1 chk("sw_wr", state, 5);
        chk("sw_mem_write", mem_write, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_mem_write", mem_write, 0);
        chk("arst_state", state, 0);
        chk("arst_outs", obs, 0);
        @(posedge clk); #1 chk("arst_hold", obs, 0);
        release_reset();

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) != 0)
                op = legal_ops[$urandom_range(0, 5)];
            else
                op = 6'($urandom);
            run_instr(op, 0, 0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
